// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory access path: funct3 codes, FSM states
// and helpers for funct3 legality, lane alignment and load extension.
package cpu_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } dmem_state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Halfwords drop bit 0, words drop both low bits.
    function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lane);
        logic [1:0] al;
        case (f3[1:0])
            2'b01:   al = {lane[1], 1'b0};
            2'b10:   al = 2'b00;
            default: al = lane;
        endcase
        return al;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] shifted);
        logic [31:0] val;
        case (f3)
            F3_B:    val = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    val = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    val = shifted;
            F3_BU:   val = {24'h0, shifted[7:0]};
            F3_HU:   val = {16'h0, shifted[15:0]};
            default: val = 32'h0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: byte-write enables and replicated store word,
// plus load extraction and sign/zero extension from a raw memory word.
module dmem_lane_fmt
    import cpu_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted   = rd_word >> {lane, 3'b000};
    assign load_data = extend_load(funct3, shifted);

    // Store data is replicated so every lane sees its byte; byte_en picks the lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byte_en[gi] = (funct3[1:0] == 2'b10) ||
                                 ((funct3[1:0] == 2'b01) && (lane[1] == LANE[1])) ||
                                 ((funct3[1:0] == 2'b00) && (lane == LANE));
            assign wr_word[gi*8 +: 8] = (funct3[1:0] == 2'b00) ? store_data[7:0] :
                                        (funct3[1:0] == 2'b01) ? store_data[(gi%2)*8 +: 8] :
                                                                 store_data[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_access_unit.sv
// Non-pipelined data-memory stage with fixed latency LAT and PC-tagged responses.
// Define DMEM_MISALIGN_CHECK_EN to report misaligned halfword/word accesses as errors.
module dmem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LAT         = 2
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_pc,
    output logic        resp_is_store,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t     state_reg, state_next;
    logic [3:0]      cnt_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     wdata_reg;
    logic            is_store_reg;
    logic            err_reg;
    logic [2:0]      f3_reg;
    logic [AW-1:0]   idx_reg;
    logic [1:0]      lane_reg;
    logic [31:0]     resp_pc_reg;
    logic            resp_is_store_reg;

    logic            req_fire;
    logic            access_done;
    logic            drop_load;
    logic            err_now;
    logic            wr_en;
    logic            rd_en;
    logic [3:0]      byte_en;
    logic [31:0]     wr_word;
    logic [31:0]     rd_word;
    logic [31:0]     load_data;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign req_fire    = req_valid && (state_reg == ST_IDLE);
    assign access_done = (state_reg == ST_ACCESS) && (cnt_reg == 4'd0);
    assign drop_load   = flush && !is_store_reg;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_now = !f3_legal(req_is_store, req_funct3) ||
                     is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign err_now = !f3_legal(req_is_store, req_funct3);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (drop_load)             state_next = ST_IDLE;
                else if (cnt_reg == 4'd0)  state_next = ST_RESP;
            end
            ST_RESP: begin
                if (drop_load || resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= 4'd0;
            resp_pc_reg       <= 32'h0;
            resp_is_store_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (req_fire) begin
                cnt_reg <= 4'(LAT - 1);
            end else if ((state_reg == ST_ACCESS) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (access_done && !drop_load) begin
                resp_pc_reg       <= pc_reg;
                resp_is_store_reg <= is_store_reg;
            end
        end
    end

    // Request capture; alignment is folded in here so the formatter sees a legal lane.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_reg       <= req_pc;
            is_store_reg <= req_is_store;
            f3_reg       <= req_funct3;
            wdata_reg    <= req_wdata;
            idx_reg      <= req_addr[AW+1:2];
            lane_reg     <= align_lane(req_funct3, req_addr[1:0]);
            err_reg      <= err_now;
        end
    end

    dmem_lane_fmt u_fmt (
        .funct3     (f3_reg),
        .lane       (lane_reg),
        .store_data (wdata_reg),
        .rd_word    (rd_word),
        .byte_en    (byte_en),
        .wr_word    (wr_word),
        .load_data  (load_data)
    );

    assign wr_en = access_done && is_store_reg && !err_reg;
    assign rd_en = access_done && !is_store_reg && !err_reg;

    // One byte-wide array per lane keeps byte writes simple; reset blocks a write on the exit edge.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mem
            logic [7:0] mem [0:DEPTH_WORDS-1];
            logic [7:0] rd_byte_reg;
            always_ff @(posedge clk) begin
                if (rstn && wr_en && byte_en[gi]) begin
                    mem[idx_reg] <= wr_word[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_byte_reg <= mem[idx_reg];
                end
            end
            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    assign req_ready     = (state_reg == ST_IDLE);
    assign resp_valid    = (state_reg == ST_RESP);
    assign resp_pc       = resp_pc_reg;
    assign resp_is_store = resp_is_store_reg;
    assign resp_err      = resp_valid && err_reg;
    assign resp_data     = (resp_valid && !is_store_reg && !err_reg) ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit (DEPTH_WORDS=1024, LAT=2).
module tb_dmem_access_unit;
    import cpu_mem_pkg::*;

    localparam int LAT_CFG = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic        resp_is_store;
    logic [31:0] resp_data;
    logic        resp_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] next_pc = 32'h0000_1000;

    always #5 clk = ~clk;

    dmem_access_unit #(.DEPTH_WORDS(1024), .LAT(LAT_CFG)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_pc        (req_pc),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_pc       (resp_pc),
        .resp_is_store (resp_is_store),
        .resp_data     (resp_data),
        .resp_err      (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Offers a request and returns #1 after the accept edge.
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc);
        int n;
        n = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        req_pc       = pc;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp_valid && lat < 50);
    endtask

    task automatic finish_resp(input string name);
        @(posedge clk);
        #1;
        check({name, "_resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic run_op(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_data, input logic exp_err);
        int lat;
        logic [31:0] pc;
        pc = next_pc;
        next_pc += 32'd4;
        send(st, f3, addr, wd, pc);
        wait_resp(lat);
        $display("op %-10s st=%0d f3=%03b addr=0x%08h pc=0x%08h lat=%0d data=0x%08h err=%0d",
                 name, st, f3, addr, pc, lat, resp_data, resp_err);
        check({name, "_lat"},   32'(lat), 32'(LAT_CFG));
        check({name, "_valid"}, 32'(resp_valid), 32'd1);
        check({name, "_pc"},    resp_pc, pc);
        check({name, "_isst"},  32'(resp_is_store), 32'(st));
        check({name, "_data"},  resp_data, exp_data);
        check({name, "_err"},   32'(resp_err), 32'(exp_err));
        finish_resp(name);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [31:0] hold_pc;

        rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_pc = 32'h0; req_is_store = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_pc",    resp_pc, 32'h0);
        check("rst_resp_isst",  32'(resp_is_store), 32'd0);
        check("rst_resp_data",  resp_data, 32'h0);
        check("rst_resp_err",   32'(resp_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_op("sw_100",  1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        run_op("lw_100",  1'b0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        run_op("sb_101",  1'b1, F3_B,  32'h101, 32'hABCDEF80, 32'h0, 1'b0);
        run_op("lb_101",  1'b0, F3_B,  32'h101, 32'h0, 32'hFFFFFF80, 1'b0);
        run_op("lbu_101", 1'b0, F3_BU, 32'h101, 32'h0, 32'h00000080, 1'b0);
        run_op("lw_100b", 1'b0, F3_W,  32'h100, 32'h0, 32'hDEAD80EF, 1'b0);
        run_op("lh_102",  1'b0, F3_H,  32'h102, 32'h0, 32'hFFFFDEAD, 1'b0);
        run_op("lhu_102", 1'b0, F3_HU, 32'h102, 32'h0, 32'h0000DEAD, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
        run_op("lw_102",  1'b0, F3_W,  32'h102, 32'h0, 32'h0, 1'b1);
`else
        run_op("lw_102",  1'b0, F3_W,  32'h102, 32'h0, 32'hDEAD80EF, 1'b0);
`endif
        run_op("lh_100",  1'b0, F3_H,  32'h100, 32'h0, 32'hFFFF80EF, 1'b0);
        run_op("sh_102",  1'b1, F3_H,  32'h102, 32'h5A5A1234, 32'h0, 1'b0);
        run_op("lw_100c", 1'b0, F3_W,  32'h100, 32'h0, 32'h123480EF, 1'b0);
        run_op("lbu_103", 1'b0, F3_BU, 32'h103, 32'h0, 32'h00000012, 1'b0);
        run_op("s011",    1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
        run_op("lw_100d", 1'b0, F3_W,  32'h100, 32'h0, 32'h123480EF, 1'b0);
        run_op("l110",    1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1);
        run_op("lw_alias", 1'b0, F3_W, 32'h1100, 32'h0, 32'h123480EF, 1'b0);

        // Back-pressure: response held for 5 cycles while a second request waits.
        resp_ready = 1'b0;
        hold_pc = next_pc;
        next_pc += 32'd4;
        send(1'b0, F3_W, 32'h100, 32'h0, hold_pc);
        wait_resp(lat);
        check("hold_lat", 32'(lat), 32'(LAT_CFG));
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = F3_BU; req_addr = 32'h101;
        req_pc = next_pc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data",  resp_data, 32'h123480EF);
            check("hold_pc",    resp_pc, hold_pc);
            check("hold_rdy",   32'(req_ready), 32'd0);
        end
        $display("op hold      pc=0x%08h held 5 cycles data=0x%08h", hold_pc, resp_data);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_valid_low", 32'(resp_valid), 32'd0);
        check("hs_idle_rdy",  32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("hs_accepted", 32'(req_ready), 32'd0);
        wait_resp(lat);
        check("hs2_lat",  32'(lat), 32'(LAT_CFG));
        check("hs2_pc",   resp_pc, next_pc);
        check("hs2_data", resp_data, 32'h00000080);
        $display("op lbu_hs    pc=0x%08h lat=%0d data=0x%08h", resp_pc, lat, resp_data);
        next_pc += 32'd4;
        finish_resp("hs2");

        // Load flushed one cycle after accept never responds.
        send(1'b0, F3_W, 32'h100, 32'h0, next_pc);
        next_pc += 32'd4;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ld_rdy",   32'(req_ready), 32'd1);
        check("flush_ld_valid", 32'(resp_valid), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check("flush_ld_never", 32'(seen), 32'd0);
        $display("op flush_ld  dropped");
        run_op("lw_postfl", 1'b0, F3_W, 32'h100, 32'h0, 32'h123480EF, 1'b0);

        // Flushed store still completes and writes.
        send(1'b1, F3_W, 32'h200, 32'h11223344, next_pc);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_resp(lat);
        check("flush_st_lat",  32'(lat + 1), 32'(LAT_CFG));
        check("flush_st_pc",   resp_pc, next_pc);
        check("flush_st_isst", 32'(resp_is_store), 32'd1);
        $display("op flush_st  pc=0x%08h valid=%0d", resp_pc, resp_valid);
        next_pc += 32'd4;
        finish_resp("flush_st");
        run_op("lw_200", 1'b0, F3_W, 32'h200, 32'h0, 32'h11223344, 1'b0);

        // Flush held in IDLE does not block acceptance; store is never dropped.
        flush = 1'b1;
        run_op("sw_300_fl", 1'b1, F3_W, 32'h300, 32'h01020304, 32'h0, 1'b0);
        flush = 1'b0;

        // Reset on the edge that would perform the store: write is lost.
        send(1'b1, F3_W, 32'h300, 32'hCAFEF00D, next_pc);
        next_pc += 32'd4;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_acc_valid", 32'(resp_valid), 32'd0);
        check("rst_acc_rdy",   32'(req_ready), 32'd1);
        check("rst_acc_pc",    resp_pc, 32'h0);
        $display("op rst_acc   store aborted");
        @(negedge clk);
        rstn = 1'b1;
        run_op("lw_300", 1'b0, F3_W, 32'h300, 32'h0, 32'h01020304, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Data-memory stage directly downstream of the load-store queue. It accepts one issued memory operation at a time: the PC tag, the computed address and the store data. It performs the access on an internal word-array data memory with a fixed latency. It then returns load data or store completion, tagged by PC, to the LSQ/completion logic. The block is non-pipelined: one operation in flight, with a valid/ready handshake on both sides.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in data memory (power of two)
LAT, 2, cycles from request accept to response valid (1..15)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush  in  1  squash an in-flight load (mispredict recovery)
req_valid  in  1  LSQ presents an operation
req_ready  out  1  unit can accept
req_pc  in  32  instruction PC, used as the match tag
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V width/sign code
req_addr  in  32  effective byte address
req_wdata  in  32  store data (rs2)
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_pc  out  32  PC of completed op
resp_is_store  out  1  echo of op type
resp_data  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned address or illegal funct3

Behaviour:
- Reset (rstn=0 at posedge): state IDLE, counter 0, req_ready=1. resp_valid, resp_pc, resp_is_store, resp_data and resp_err all 0. Memory contents are not cleared.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge, capture pc, op, funct3, addr and wdata.
  - Load counter with LAT-1 and go to ACCESS.
- ACCESS:
  - req_ready=0.
  - Decrement the counter each cycle.
  - When counter==0, perform the access and move to RESP with resp_valid=1.
  - Result: resp_valid rises exactly LAT edges after the accept edge.
- RESP:
  - Hold all resp_* stable until resp_valid&&resp_ready at an edge.
  - Then go to IDLE. A new request can be accepted on the cycle after the handshake; there is no same-cycle turnaround.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo memory size.
  - Byte lane = addr[1:0], little-endian.
- Loads:
  - 000 LB and 001 LH sign-extend.
  - 100 LBU and 101 LHU zero-extend.
  - 010 LW returns the full word.
- Stores:
  - 000 SB and 001 SH write only the selected byte or halfword lanes.
  - 010 SW writes the full word.
  - The write occurs at the ACCESS exit edge.
- Errors:
  - Illegal funct3: loads other than 000/001/010/100/101, stores other than 000/001/010. Result: no memory write, resp_err=1, resp_data=0, same latency.
  - Misaligned access: see Optional Feature.
- Flush:
  - A load in ACCESS or RESP is dropped: no response, return to IDLE next edge, resp_valid=0.
  - A store is never dropped, since the LSQ issues stores only at retirement.
  - flush in IDLE has no effect; a request offered in the same cycle is still accepted.
- Reset mid-operation aborts everything, including a pending store write. The store is lost.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, performs no read or write. It responds with resp_err=1 and resp_data=0 at the normal latency.
- Undefined: the low address bits are forced to alignment (halfword clears bit 0, word clears bits 1:0) and the access proceeds. resp_err then reflects only illegal funct3.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum: ST_IDLE, ST_ACCESS, ST_RESP
  - helper functions for lane-select and extension
- One sub-module is natural: dmem_lane_fmt, a combinational unit that builds the byte-write mask and store-merge word and the load extract/extend. The FSM, counter and memory array stay in the top.

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100, LAT=2 → store resp 2 edges after accept (resp_err=0, resp_data=0); load resp_data=0xDEADBEEF.
- SB 0x80 @0x101 over the above, then LB @0x101 and LBU @0x101 → 0xFFFFFF80 and 0x00000080; LW @0x100 → 0xDEAD80EF.
- LH @0x102 → 0xFFFFDEAD; LHU → 0x0000DEAD; LW @0x102 → with macro resp_err=1, data 0; without macro 0xDEAD80EF.
- Hold resp_ready=0 for 5 cycles after load resp_valid → outputs stable, req_ready=0; second request accepted only the cycle after the handshake.
- Load accepted, flush one cycle later → no resp_valid ever; next request accepted normally. The same sequence with a store → write occurs and resp_valid still asserts.
- Store with funct3=011 → resp_err=1 and memory unchanged. Address 0x1000+0x100 with DEPTH_WORDS=1024 aliases 0x100. Reset asserted in ACCESS → resp_valid=0 and req_ready=1 next edge.
